// File: rtl/fsm_serial_rx.sv
// fsm_serial_rx: serial frame receiver driven by an external bit strobe.
//
// Frame on the line: start bit (1), DATA_W payload bits MSB first,
// optional even-parity bit, stop bit (0). The line idles at 0.
// The line is sampled only on clock edges where enable=1; cycles with
// enable=0 freeze the receiver completely.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a start bit (sampled 1) on the line
// DATA   | collecting payload bits into the shift register, MSB first
// PARITY | capturing the received even-parity bit
// STOP   | checking the stop bit and reporting the frame result
//
// Result pulses (rx_valid / parity_err / frame_err) are registered, so
// they appear in the cycle after the edge that sampled the stop bit.
// A framing error takes priority over a parity error, so at most one
// pulse is ever raised per frame.

module fsm_serial_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Counter is wide enough to hold DATA_W itself, so it never wraps
    // inside a frame.
    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic              par_bit;
    logic              par_bit_nxt;
    logic [DATA_W-1:0] rx_data_nxt;
    logic              rx_valid_nxt;
    logic              parity_err_nxt;
    logic              frame_err_nxt;
    logic              parity_ok;

    // State register plus datapath and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            par_bit    <= par_bit_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            parity_err <= parity_err_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // Next-state logic: advance only on enabled samples.
    always_comb begin
        state_nxt = state;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (data) begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Datapath next values: bit counter, payload shift register, parity bit.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        par_bit_nxt = par_bit;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (data) begin
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shift_nxt   = {shift_reg[DATA_W-2:0], data};
                    bit_cnt_nxt = bit_cnt + CNT_ONE;
                end
                PARITY: begin
                    par_bit_nxt = data;
                end
                default: begin
                    bit_cnt_nxt = bit_cnt;
                end
            endcase
        end
    end

    // Even parity over payload plus received parity bit must be zero.
    always_comb begin
        if (PARITY_EN != 0) begin
            parity_ok = ~(^shift_reg ^ par_bit);
        end else begin
            parity_ok = 1'b1;
        end
    end

    // Output logic: frame verdict on the stop sample, busy from state.
    always_comb begin
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        parity_err_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        busy           = (state != IDLE);
        if (enable && (state == STOP)) begin
            if (data) begin
                frame_err_nxt = 1'b1;
            end else if (!parity_ok) begin
                parity_err_nxt = 1'b1;
            end else begin
                rx_valid_nxt = 1'b1;
                rx_data_nxt  = shift_reg;
            end
        end
    end

endmodule
